// File: rtl/vga_time_overlay.sv
// vga_time_overlay: BCD elapsed-time timer drawn as seven-segment glyphs over an
// RGB565 pixel stream with a fixed two-cycle pass-through latency.
module vga_time_overlay #(
  parameter int unsigned CLK_HZ     = 25_000_000,
  parameter int unsigned X_W        = 10,
  parameter int unsigned Y_W        = 10,
  parameter int unsigned POS_X      = 16,
  parameter int unsigned POS_Y      = 16,
  parameter int unsigned SEG_LEN    = 8,
  parameter int unsigned SEG_THK    = 2,
  parameter int unsigned CELL_GAP   = 4,
  parameter int unsigned SHOW_HOURS = 0,
  parameter logic [15:0] FG_COLOR   = 16'hF800
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           run,
  input  logic           clear,
  input  logic           pix_valid_in,
  input  logic [X_W-1:0] x_in,
  input  logic [Y_W-1:0] y_in,
  input  logic [15:0]    rgb_in,
  output logic           pix_valid_out,
  output logic [15:0]    rgb_out,
  output logic [23:0]    time_bcd,
  output logic           sec_tick
);

  localparam int unsigned T    = SEG_THK;
  localparam int unsigned L    = SEG_LEN;
  localparam int unsigned DW   = L + 2 * T;
  localparam int unsigned DH   = 2 * L + 3 * T;
  localparam int unsigned CW   = 3 * T;
  localparam int unsigned G    = CELL_GAP;
  localparam bit          HRS  = (SHOW_HOURS != 0);
  localparam int unsigned HOFF = HRS ? (2 * DW + CW + 3 * G) : 0;
  localparam int unsigned PW   = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;

  localparam logic [PW-1:0] PMAX  = PW'(CLK_HZ - 1);
  localparam logic [PW-1:0] PHALF = PW'(CLK_HZ / 2);

  // Cell origins relative to the box, plus horizontal glyph geometry
  localparam logic [X_W-1:0] XPOS = X_W'(POS_X);
  localparam logic [X_W-1:0] XH1  = X_W'(0);
  localparam logic [X_W-1:0] XH0  = X_W'(DW + G);
  localparam logic [X_W-1:0] XC1  = X_W'(2 * DW + 2 * G);
  localparam logic [X_W-1:0] XM1  = X_W'(HOFF);
  localparam logic [X_W-1:0] XM0  = X_W'(HOFF + DW + G);
  localparam logic [X_W-1:0] XC2  = X_W'(HOFF + 2 * DW + 2 * G);
  localparam logic [X_W-1:0] XS1  = X_W'(HOFF + 2 * DW + CW + 3 * G);
  localparam logic [X_W-1:0] XS0  = X_W'(HOFF + 3 * DW + CW + 4 * G);
  localparam logic [X_W-1:0] XDW  = X_W'(DW);
  localparam logic [X_W-1:0] XCW  = X_W'(CW);
  localparam logic [X_W-1:0] UT   = X_W'(T);
  localparam logic [X_W-1:0] UTL  = X_W'(T + L);
  localparam logic [X_W-1:0] U2T  = X_W'(2 * T);

  // Vertical glyph geometry
  localparam logic [Y_W-1:0] YPOS  = Y_W'(POS_Y);
  localparam logic [Y_W-1:0] YDH   = Y_W'(DH);
  localparam logic [Y_W-1:0] VT    = Y_W'(T);
  localparam logic [Y_W-1:0] VTL   = Y_W'(T + L);
  localparam logic [Y_W-1:0] VL2T  = Y_W'(L + 2 * T);
  localparam logic [Y_W-1:0] V2L2T = Y_W'(2 * L + 2 * T);
  localparam logic [Y_W-1:0] VC1   = Y_W'(L / 2);
  localparam logic [Y_W-1:0] VC1E  = Y_W'(L / 2 + T);
  localparam logic [Y_W-1:0] VC2   = Y_W'(L + 2 * T + L / 2);
  localparam logic [Y_W-1:0] VC2E  = Y_W'(L + 2 * T + L / 2 + T);

  localparam logic [2:0] CELL_NONE  = 3'd0;
  localparam logic [2:0] CELL_COLON = 3'd7;

  // Segment set {a,b,c,d,e,f,g} for a BCD digit; codes 10-15 are blank
  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1111110;
      4'd1:    seg7 = 7'b0110000;
      4'd2:    seg7 = 7'b1101101;
      4'd3:    seg7 = 7'b1111001;
      4'd4:    seg7 = 7'b0110011;
      4'd5:    seg7 = 7'b1011011;
      4'd6:    seg7 = 7'b1011111;
      4'd7:    seg7 = 7'b1110000;
      4'd8:    seg7 = 7'b1111111;
      4'd9:    seg7 = 7'b1111011;
      default: seg7 = 7'b0000000;
    endcase
  endfunction

  // True when local (u,v) falls on a lit segment of digit d
  function automatic logic seg_hit(input logic [3:0] d, input logic [X_W-1:0] u,
                                   input logic [Y_W-1:0] v);
    logic [6:0] s;
    logic       uh, ul, ur, vu, vl;
    s  = seg7(d);
    uh = (u >= UT) && (u < UTL);
    ul = (u < UT);
    ur = (u >= UTL);
    vu = (v >= VT) && (v < VTL);
    vl = (v >= VL2T) && (v < V2L2T);
    seg_hit = (s[6] && (v < VT) && uh) ||
              (s[5] && ur && vu) ||
              (s[4] && ur && vl) ||
              (s[3] && (v >= V2L2T) && uh) ||
              (s[2] && ul && vl) ||
              (s[1] && ul && vu) ||
              (s[0] && (v >= VTL) && (v < VL2T) && uh);
  endfunction

  function automatic logic in_cell(input logic [X_W-1:0] rx, input logic [X_W-1:0] x0,
                                   input logic [X_W-1:0] w);
    in_cell = (rx >= x0) && ((rx - x0) < w);
  endfunction

  logic [PW-1:0] presc_q, presc_d;
  logic [3:0]    s0_q, s1_q, m0_q, m1_q, h0_q, h1_q;
  logic [3:0]    s0_d, s1_d, m0_d, m1_d, h0_d, h1_d;
  logic          sec_tick_q, sec_tick_d;
  logic [23:0]   shadow_q, shadow_d;
  logic          tick_c, c1_c, c2_c, c3_c, c4_c;

  logic           val1_q, blink1_q;
  logic [15:0]    rgb1_q;
  logic [2:0]     cell1_q, cell_c;
  logic [X_W-1:0] u1_q, u_c, rx_c;
  logic [Y_W-1:0] v1_q, ry_c;
  logic           val2_q;
  logic [15:0]    rgb2_q, rgb2_d;
  logic           blink_c, hit_c;
  logic [3:0]     dsel_c;

  assign tick_c = run && (presc_q == PMAX);
  assign c1_c   = tick_c && (s0_q == 4'd9);
  assign c2_c   = c1_c && (s1_q == 4'd5);
  assign c3_c   = c2_c && (m0_q == 4'd9);
  assign c4_c   = c3_c && (m1_q == 4'd5);

  // Timer next state: prescaler, BCD cascade, clear priority, shadow capture
  always_comb begin
    presc_d    = presc_q;
    s0_d       = s0_q;
    s1_d       = s1_q;
    m0_d       = m0_q;
    m1_d       = m1_q;
    h0_d       = h0_q;
    h1_d       = h1_q;
    sec_tick_d = 1'b0;
    shadow_d   = shadow_q;
    if (pix_valid_in && (x_in == '0) && (y_in == '0)) shadow_d = time_bcd;
    if (clear) begin
      presc_d = '0;
      s0_d    = 4'd0;
      s1_d    = 4'd0;
      m0_d    = 4'd0;
      m1_d    = 4'd0;
      h0_d    = 4'd0;
      h1_d    = 4'd0;
    end else begin
      if (run) presc_d = tick_c ? '0 : presc_q + 1'b1;
      sec_tick_d = tick_c;
      if (tick_c) s0_d = (s0_q == 4'd9) ? 4'd0 : s0_q + 4'd1;
      if (c1_c)   s1_d = (s1_q == 4'd5) ? 4'd0 : s1_q + 4'd1;
      if (c2_c)   m0_d = (m0_q == 4'd9) ? 4'd0 : m0_q + 4'd1;
      if (c3_c)   m1_d = (m1_q == 4'd5) ? 4'd0 : m1_q + 4'd1;
      if (HRS && c4_c) begin
        if ((h1_q == 4'd2) && (h0_q == 4'd3)) begin
          h1_d = 4'd0;
          h0_d = 4'd0;
        end else if (h0_q == 4'd9) begin
          h0_d = 4'd0;
          h1_d = h1_q + 4'd1;
        end else begin
          h0_d = h0_q + 4'd1;
        end
      end
    end
  end

  // Stage 1 decode: which cell the pixel falls in, local coordinates, colon blink
  always_comb begin
    rx_c    = x_in - XPOS;
    ry_c    = y_in - YPOS;
    cell_c  = CELL_NONE;
    u_c     = '0;
    blink_c = !run || (presc_q < PHALF);
    if ((x_in >= XPOS) && (y_in >= YPOS) && (ry_c < YDH)) begin
      if (HRS && in_cell(rx_c, XH1, XDW)) begin
        cell_c = 3'd1;
        u_c    = rx_c - XH1;
      end else if (HRS && in_cell(rx_c, XH0, XDW)) begin
        cell_c = 3'd2;
        u_c    = rx_c - XH0;
      end else if (HRS && in_cell(rx_c, XC1, XCW)) begin
        cell_c = CELL_COLON;
        u_c    = rx_c - XC1;
      end else if (in_cell(rx_c, XM1, XDW)) begin
        cell_c = 3'd3;
        u_c    = rx_c - XM1;
      end else if (in_cell(rx_c, XM0, XDW)) begin
        cell_c = 3'd4;
        u_c    = rx_c - XM0;
      end else if (in_cell(rx_c, XC2, XCW)) begin
        cell_c = CELL_COLON;
        u_c    = rx_c - XC2;
      end else if (in_cell(rx_c, XS1, XDW)) begin
        cell_c = 3'd5;
        u_c    = rx_c - XS1;
      end else if (in_cell(rx_c, XS0, XDW)) begin
        cell_c = 3'd6;
        u_c    = rx_c - XS0;
      end
    end
  end

  // Stage 2 hit test against the shadow digits, then colour select
  always_comb begin
    case (cell1_q)
      3'd1:    dsel_c = shadow_q[23:20];
      3'd2:    dsel_c = shadow_q[19:16];
      3'd3:    dsel_c = shadow_q[15:12];
      3'd4:    dsel_c = shadow_q[11:8];
      3'd5:    dsel_c = shadow_q[7:4];
      default: dsel_c = shadow_q[3:0];
    endcase
    hit_c = 1'b0;
    if (cell1_q == CELL_COLON) begin
      hit_c = blink1_q && (u1_q >= UT) && (u1_q < U2T) &&
              (((v1_q >= VC1) && (v1_q < VC1E)) || ((v1_q >= VC2) && (v1_q < VC2E)));
    end else if (cell1_q != CELL_NONE) begin
      hit_c = seg_hit(dsel_c, u1_q, v1_q);
    end
    rgb2_d = hit_c ? FG_COLOR : rgb1_q;
  end

  // Timer, shadow and pixel pipeline registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q    <= '0;
      s0_q       <= 4'd0;
      s1_q       <= 4'd0;
      m0_q       <= 4'd0;
      m1_q       <= 4'd0;
      h0_q       <= 4'd0;
      h1_q       <= 4'd0;
      sec_tick_q <= 1'b0;
      shadow_q   <= '0;
      val1_q     <= 1'b0;
      rgb1_q     <= '0;
      cell1_q    <= CELL_NONE;
      u1_q       <= '0;
      v1_q       <= '0;
      blink1_q   <= 1'b0;
      val2_q     <= 1'b0;
      rgb2_q     <= '0;
    end else begin
      presc_q    <= presc_d;
      s0_q       <= s0_d;
      s1_q       <= s1_d;
      m0_q       <= m0_d;
      m1_q       <= m1_d;
      h0_q       <= h0_d;
      h1_q       <= h1_d;
      sec_tick_q <= sec_tick_d;
      shadow_q   <= shadow_d;
      val1_q     <= pix_valid_in;
      rgb1_q     <= rgb_in;
      cell1_q    <= cell_c;
      u1_q       <= u_c;
      v1_q       <= ry_c;
      blink1_q   <= blink_c;
      val2_q     <= val1_q;
      rgb2_q     <= rgb2_d;
    end
  end

  assign time_bcd      = {h1_q, h0_q, m1_q, m0_q, s1_q, s0_q};
  assign sec_tick      = sec_tick_q;
  assign pix_valid_out = val2_q;
  assign rgb_out       = rgb2_q;

endmodule

// File: doc/vga_time_overlay.md
Name: vga_time_overlay

Overview:
- Parametrised elapsed-time overlay for the camera VGA path.
- Keeps a BCD run timer in MM:SS or HH:MM:SS format, with run/pause/clear control.
- Draws the timer as seven-segment glyphs with blinking colons into a 16-bit RGB565 pixel stream.
- Sits between the frame-buffer read side and the VGA output; the pixel stream passes through with fixed 2-cycle latency.

Parameters:
- CLK_HZ, 25_000_000: clock cycles per timer second.
- X_W, 10: width of x_in.
- Y_W, 10: width of y_in.
- POS_X, 16: left pixel column of the overlay box.
- POS_Y, 16: top pixel row of the overlay box.
- SEG_LEN, 8: segment length in pixels, even, >=4.
- SEG_THK, 2: segment thickness in pixels, >=1.
- CELL_GAP, 4: blank pixels between adjacent cells.
- SHOW_HOURS, 0: 0 selects MM:SS (4 digits); 1 selects HH:MM:SS (6 digits).
- FG_COLOR, 16'hF800: RGB565 colour of lit segments and colon dots.

Ports:
- clk  in  1  pixel/system clock
- rst_n  in  1  asynchronous active-low reset
- run  in  1  1 = timer counts, 0 = paused
- clear  in  1  synchronous timer clear, single-cycle or level
- pix_valid_in  in  1  qualifies x_in, y_in, rgb_in
- x_in  in  X_W  pixel column
- y_in  in  Y_W  pixel row
- rgb_in  in  16  source pixel, RGB565
- pix_valid_out  out  1  pix_valid_in delayed 2 cycles
- rgb_out  out  16  overlaid pixel, aligned with pix_valid_out
- time_bcd  out  24  live time {h1,h0,m1,m0,s1,s0}, 4 bits each; h digits are 0 when SHOW_HOURS=0
- sec_tick  out  1  one-cycle pulse on each timer increment

Behaviour:
Reset (rst_n low, asynchronous):
- All outputs 0.
- Prescaler, all BCD digits, shadow digits and pipeline registers 0.

Prescaler:
- Counts 0..CLK_HZ-1 while run=1, then wraps to 0.
- Holds its value while run=0.
- The tick condition is prescaler==CLK_HZ-1 with run=1.
- sec_tick is registered, high in the cycle after the tick condition.

Clear:
- clear=1 zeroes the prescaler and all digits on the next edge.
- clear has priority over a simultaneous tick: the result is 00:00(:00) and sec_tick=0.

BCD cascade on tick:
- s0 counts 0-9; on 9 it wraps to 0 and carries.
- s1 counts 0-5.
- m0 counts 0-9.
- m1 counts 0-5.
- With SHOW_HOURS=0: 59:59 rolls to 00:00.
- With SHOW_HOURS=1: hours count 00-23; 23:59:59 rolls to 00:00:00 (h0 wraps at 9 normally and at 3 when h1==2).
- All digit updates for one tick land in the same cycle.

Shadow register (tear-free display):
- Loads the live digits when pix_valid_in=1 with x_in==0 and y_in==0.
- Rendering uses only the shadow register. time_bcd shows the live value.

Geometry (local parameters, no dividers):
- Digit cell: DW = SEG_LEN+2*SEG_THK wide, DH = 2*SEG_LEN+3*SEG_THK tall.
- Colon cell: 3*SEG_THK wide.
- Cell order is left to right: [h1 h0 :] m1 m0 : s1 s0, with CELL_GAP between cells.
- The box origin is (POS_X, POS_Y). Pixels outside every cell pass through unchanged.

Segment hit test, with local (u,v) inside a digit cell and T = SEG_THK, L = SEG_LEN:
- a: v<T, T<=u<T+L.
- g: L+T<=v<L+2T, T<=u<T+L.
- d: v>=2L+2T, T<=u<T+L.
- f: u<T, T<=v<T+L.
- b: u>=T+L, T<=v<T+L.
- e: u<T, 2T+L<=v<2T+2L.
- c: u>=T+L, 2T+L<=v<2T+2L.
- Digit encodings are standard seven-segment 0-9. Codes 10-15 light no segment.

Colon:
- Dots are at u in [T,2T).
- Upper dot: v in [L/2, L/2+T). Lower dot: v in [L+2T+L/2, L+2T+L/2+T).
- Colons are visible when run=0, or when prescaler < CLK_HZ/2. Otherwise colons are hidden (1 Hz blink).

Pipeline:
- Stage 1 registers rgb_in, valid, cell index, local (u,v) and blink state.
- Stage 2 registers the hit result; rgb_out = hit ? FG_COLOR : delayed rgb_in.
- When pix_valid_in=0, the stages still advance. rgb_out is don't-care when pix_valid_out=0.
- Reset asserted mid-frame clears the pipeline immediately. No partial-frame recovery logic is required.

Test Plan:
- CLK_HZ=10, run=1 for 600 cycles, SHOW_HOURS=0 -> sec_tick pulses 60 times; time_bcd = 0x000100 (01:00); rollover 59:59 -> 00:00 verified after 36000 cycles.
- CLK_HZ=10, SHOW_HOURS=1, digits forced near 23:59:59, one tick -> time_bcd = 0x000000, one sec_tick pulse.
- run low for 25 cycles mid-second -> prescaler and time_bcd frozen, colon continuously visible; counting resumes from the same prescaler value.
- clear asserted in the tick cycle -> time_bcd = 0, no sec_tick, prescaler = 0.
- Shadow = 8 (all defaults), scan the full box -> rgb_out = 16'hF800 exactly on the segment pixel set, rgb_in elsewhere; pixel (POS_X, POS_Y+SEG_THK) is lit (segment f); pixel (POS_X, POS_Y) is not lit (corner).
- Timer increments mid-frame -> displayed digits change only after the next (0,0) pixel; pix_valid_out equals pix_valid_in delayed exactly 2 cycles.
